// File: rtl/sparc_win_pkg.sv
// Shared definitions for the register-window spill/fill controller:
// controller states, window geometry and window/WIM arithmetic helpers.
package sparc_win_pkg;

  localparam int NWIN  = 4;   // number of register windows
  localparam int NREG  = 16;  // words spilled/filled per window (r16..r31)
  localparam int CWP_W = 2;   // width of a window pointer
  localparam int WIM_W = 4;   // width of the window invalid mask
  localparam int CNT_W = 4;   // width of the word counter

  localparam logic [4:0] RF_BASE = 5'd16;  // first logical register moved

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SPILL,
    FILL_WAIT,
    FILL_WR,
    UPDATE,
    DONE
  } state_t;

  // Previous window, wrapping below 0 to n-1.
  function automatic logic [CWP_W-1:0] win_dec(input logic [CWP_W-1:0] w, input int n);
    if (w == '0) return CWP_W'(n - 1);
    return w - CWP_W'(1);
  endfunction

  // Next window, wrapping from n-1 back to 0.
  function automatic logic [CWP_W-1:0] win_inc(input logic [CWP_W-1:0] w, input int n);
    if (int'(w) >= n - 1) return '0;
    return w + CWP_W'(1);
  endfunction

  // Rotate the low n bits of the mask right by one (used after a spill).
  function automatic logic [WIM_W-1:0] wim_ror(input logic [WIM_W-1:0] w, input int n);
    logic [WIM_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIM_W; i++)
      if (i < n) r[i] = w[CWP_W'((i + 1) % n)];
    return r;
  endfunction

  // Rotate the low n bits of the mask left by one (used after a fill).
  function automatic logic [WIM_W-1:0] wim_rol(input logic [WIM_W-1:0] w, input int n);
    logic [WIM_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIM_W; i++)
      if (i < n) r[i] = w[CWP_W'((i + n - 1) % n)];
    return r;
  endfunction

endpackage

// File: rtl/win_word_counter.sv
// Word index counter for a spill/fill burst: synchronous clear, count
// enable, and a terminal-count flag on the last word of the window.
module win_word_counter
  import sparc_win_pkg::*;
#(
  parameter int LAST = NREG - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Count words; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  assign tc = (count == CNT_W'(LAST));

endmodule

// File: rtl/window_spill_fill_ctrl.sv
// Register-window SAVE/RESTORE controller. Moves the target window to or
// from memory when the WIM marks it invalid, then updates CWP and WIM.
//
// Memory handshake: mem_en is a request held high (with stable mem_addr,
// mem_rw and mem_wdata) until a cycle in which MFC=1; that cycle completes
// the transfer. MFC seen while mem_en=0 carries no meaning and is ignored.
module window_spill_fill_ctrl
  import sparc_win_pkg::*;
#(
  parameter int NWIN = sparc_win_pkg::NWIN,
  parameter int NREG = sparc_win_pkg::NREG
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic [CWP_W-1:0] cwp_in,
  input  logic [WIM_W-1:0] wim_in,
  input  logic [31:0]      sp_in,
  output logic [CWP_W-1:0] cwp_out,
  output logic             cwp_we,
  output logic [WIM_W-1:0] wim_out,
  output logic             wim_we,
  output logic [CWP_W-1:0] rf_win,
  output logic [4:0]       rf_addr,
  output logic             rf_we,
  output logic [31:0]      rf_wdata,
  input  logic [31:0]      rf_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_rw,
  output logic             mem_en,
  input  logic [31:0]      mem_rdata,
  input  logic             MFC,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             underflow,
  output state_t           state_dbg
);

  state_t           state;
  logic             op_save;
  logic [CWP_W-1:0] tgt;
  logic [CWP_W-1:0] tgt_next;
  logic [WIM_W-1:0] wim_r;
  logic [31:0]      sp_r;
  logic             mfc_ok;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  win_word_counter #(.LAST(NREG - 1)) u_cnt (
    .clk   (Clk),
    .rst   (RESET),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Target window of an incoming request; save wins over restore.
  always_comb begin
    tgt_next = save_req ? win_dec(cwp_in, NWIN) : win_inc(cwp_in, NWIN);
  end

  // Word counter control: cleared on entry, stepped on each finished word.
  always_comb begin
    mfc_ok  = MFC && mem_en;
    cnt_clr = (state == CHECK);
    cnt_en  = 1'b0;
    if (state == SPILL && mfc_ok && !cnt_tc) cnt_en = 1'b1;
    if (state == FILL_WR && !cnt_tc)         cnt_en = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign mem_wdata = (mem_en && mem_rw) ? rf_rdata : '0;
  assign state_dbg = state;

  // Main controller: accept, trap check, word transfers, PSR update.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      op_save   <= 1'b0;
      tgt       <= '0;
      wim_r     <= '0;
      sp_r      <= '0;
      cwp_out   <= '0;
      cwp_we    <= 1'b0;
      wim_out   <= '0;
      wim_we    <= 1'b0;
      rf_win    <= '0;
      rf_addr   <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_en    <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cwp_we <= 1'b0;
      wim_we <= 1'b0;
      rf_we  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (save_req || restore_req) begin
            op_save   <= save_req;
            tgt       <= tgt_next;
            wim_r     <= wim_in;
            sp_r      <= sp_in;
            overflow  <= save_req && wim_in[tgt_next];
            underflow <= !save_req && wim_in[tgt_next];
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (!wim_r[tgt]) begin
            // Target window valid: only the pointer moves.
            cwp_out <= tgt;
            cwp_we  <= 1'b1;
            done    <= 1'b1;
            state   <= UPDATE;
          end else begin
            rf_win   <= tgt;
            rf_addr  <= RF_BASE;
            mem_addr <= sp_r;
            mem_rw   <= op_save;
            mem_en   <= 1'b1;
            state    <= op_save ? SPILL : FILL_WAIT;
          end
        end
        SPILL: begin
          if (mfc_ok) begin
            if (cnt_tc) begin
              mem_en  <= 1'b0;
              mem_rw  <= 1'b0;
              cwp_out <= tgt;
              cwp_we  <= 1'b1;
              wim_out <= wim_ror(wim_r, NWIN);
              wim_we  <= 1'b1;
              state   <= UPDATE;
            end else begin
              rf_addr  <= RF_BASE + {1'b0, cnt} + 5'd1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        FILL_WAIT: begin
          if (mfc_ok) begin
            mem_en   <= 1'b0;
            rf_we    <= 1'b1;
            rf_wdata <= mem_rdata;
            state    <= FILL_WR;
          end
        end
        FILL_WR: begin
          if (cnt_tc) begin
            cwp_out <= tgt;
            cwp_we  <= 1'b1;
            wim_out <= wim_rol(wim_r, NWIN);
            wim_we  <= 1'b1;
            state   <= UPDATE;
          end else begin
            rf_addr  <= RF_BASE + {1'b0, cnt} + 5'd1;
            mem_addr <= mem_addr + 32'd4;
            mem_en   <= 1'b1;
            state    <= FILL_WAIT;
          end
        end
        UPDATE: begin
          // A no-trap operation already pulsed done alongside cwp_we.
          if (done) begin
            state <= IDLE;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// Bench for window_spill_fill_ctrl: directed SAVE/RESTORE scenarios with a
// memory responder, an expected-event queue and a monitor that checks every
// memory transfer, register write, PSR strobe and done pulse.
module tb_window_spill_fill_ctrl;
  import sparc_win_pkg::*;

  localparam int W = 72;
  localparam logic [7:0] K_MWR  = 8'd1;
  localparam logic [7:0] K_MRD  = 8'd2;
  localparam logic [7:0] K_RFWR = 8'd3;
  localparam logic [7:0] K_CWP  = 8'd4;
  localparam logic [7:0] K_WIM  = 8'd5;
  localparam logic [7:0] K_DONE = 8'd6;

  logic        Clk = 1'b0;
  logic        RESET;
  logic        save_req, restore_req;
  logic [1:0]  cwp_in;
  logic [3:0]  wim_in;
  logic [31:0] sp_in;
  logic [1:0]  cwp_out;
  logic        cwp_we;
  logic [3:0]  wim_out;
  logic        wim_we;
  logic [1:0]  rf_win;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw, mem_en, MFC;
  logic        busy, done, overflow, underflow;
  state_t      state_dbg;

  logic        mfc_r = 1'b0;
  logic        mfc_spur = 1'b0;
  int          mfc_cnt = 0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_mem_wr = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;

  window_spill_fill_ctrl dut (
    .Clk(Clk), .RESET(RESET), .save_req(save_req), .restore_req(restore_req),
    .cwp_in(cwp_in), .wim_in(wim_in), .sp_in(sp_in),
    .cwp_out(cwp_out), .cwp_we(cwp_we), .wim_out(wim_out), .wim_we(wim_we),
    .rf_win(rf_win), .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_en(mem_en), .mem_rdata(mem_rdata), .MFC(MFC),
    .busy(busy), .done(done), .overflow(overflow), .underflow(underflow),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / environment models ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Register file contents: a recognisable pattern per window/register.
  assign rf_rdata  = 32'hC0DE_0000 | {22'd0, rf_win, 3'd0, rf_addr};
  // Memory contents: derived from the address.
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
  assign MFC       = mfc_r | mfc_spur;

  // Memory responder: MFC rises in the second cycle after a request starts.
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (!mem_en) begin
        mfc_cnt = 0;
        mfc_r   = 1'b0;
      end else if (mfc_r) begin
        mfc_r   = 1'b0;
        mfc_cnt = 0;
      end else begin
        mfc_cnt++;
        if (mfc_cnt == 2) mfc_r = 1'b1;
      end
    end
  end

  function automatic logic [31:0] rf_pat(input int win, input int reg_no);
    return 32'hC0DE_0000 | 32'(win * 256 + reg_no);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push(input logic [7:0] kind, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({kind, a, d});
  endtask

  task automatic check_evt(input logic [7:0] kind, input logic [31:0] a, input logic [31:0] d);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {kind, a, d};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h, required no event", kind, a, d);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_errors++;
        $display("FAIL event: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h",
                 act[71:64], act[63:32], act[31:0], exp[71:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  // Monitor: every visible DUT action is compared against the queue.
  initial begin
    forever begin
      @(negedge Clk);
      if (!RESET) begin
        if (mem_en && MFC) begin
          if (mem_rw) begin
            check_evt(K_MWR, mem_addr, mem_wdata);
            n_mem_wr++;
          end else begin
            check_evt(K_MRD, mem_addr, 32'd0);
          end
        end
        if (rf_we)  check_evt(K_RFWR, 32'({rf_win, rf_addr}), rf_wdata);
        if (wim_we) check_evt(K_WIM, 32'(wim_out), 32'd0);
        if (cwp_we) check_evt(K_CWP, 32'(cwp_out), 32'd0);
        if (done) begin
          check_evt(K_DONE, 32'({overflow, underflow}), 32'd0);
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic s, input logic r, input logic [1:0] c,
                        input logic [3:0] w, input logic [31:0] sp);
    @(negedge Clk);
    save_req = s; restore_req = r; cwp_in = c; wim_in = w; sp_in = sp;
    req_cyc = cyc;
    @(negedge Clk);
    save_req = 1'b0; restore_req = 1'b0;
    // Scramble inputs: the controller must work from its latched copies.
    cwp_in = 2'($urandom_range(0, 3));
    wim_in = 4'($urandom_range(0, 15));
    sp_in  = $urandom;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge Clk);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_complete: got idle=%0d pending=%0d, required idle=1 pending=0",
               name, ok, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [127:0] outs_vec();
    return 128'({cwp_out, cwp_we, wim_out, wim_we, rf_win, rf_addr, rf_we, rf_wdata,
                 mem_addr, mem_wdata, mem_rw, mem_en, busy, done, overflow, underflow});
  endfunction

  task automatic check_outs_zero(input string name);
    n_checks++;
    if (outs_vec() !== 128'd0) begin
      n_errors++;
      $display("FAIL %s: got outputs=%h, required all zero", name, outs_vec());
    end
  endtask

  task automatic push_spill(input logic [31:0] sp, input int win, input logic [3:0] wim_new);
    for (int k = 0; k < NREG; k++) push(K_MWR, sp + 32'(4 * k), rf_pat(win, 16 + k));
    push(K_WIM, 32'(wim_new), 32'd0);
    push(K_CWP, 32'(win), 32'd0);
    push(K_DONE, 32'd2, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    cwp_in = '0; wim_in = '0; sp_in = '0;
    repeat (2) @(negedge Clk);
    check_outs_zero("reset_state");
    RESET = 1'b0;
    repeat (2) @(negedge Clk);

    // No-trap save, cwp=2 -> 1, done two cycles after the request.
    push(K_CWP, 32'd1, 32'd0);
    push(K_DONE, 32'd0, 32'd0);
    do_req(1'b1, 1'b0, 2'd2, 4'b0001, 32'h100);
    wait_idle("save_notrap");
    n_checks++;
    if (done_cyc - req_cyc != 2) begin
      n_errors++;
      $display("FAIL save_latency: got %0d cycles, required 2", done_cyc - req_cyc);
    end

    // Window wrap without trap.
    push(K_CWP, 32'd3, 32'd0); push(K_DONE, 32'd0, 32'd0);
    do_req(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0);
    wait_idle("save_wrap");
    push(K_CWP, 32'd0, 32'd0); push(K_DONE, 32'd0, 32'd0);
    do_req(1'b0, 1'b1, 2'd3, 4'b0000, 32'h0);
    wait_idle("restore_wrap");

    // Spurious MFC while idle must do nothing.
    @(negedge Clk); mfc_spur = 1'b1;
    @(negedge Clk); mfc_spur = 1'b0;
    wait_idle("spurious_mfc");

    // Overflow spill of window 0 to 0x180.
    push_spill(32'h180, 0, 4'b1000);
    do_req(1'b1, 1'b0, 2'd1, 4'b0001, 32'h180);
    wait_idle("spill");

    // Underflow fill of window 0 from 0x180.
    for (int k = 0; k < NREG; k++) begin
      push(K_MRD, 32'h180 + 32'(4 * k), 32'd0);
      push(K_RFWR, 32'(16 + k), (32'h180 + 32'(4 * k)) ^ 32'h5A5A_0000);
    end
    push(K_WIM, 32'b0010, 32'd0);
    push(K_CWP, 32'd0, 32'd0);
    push(K_DONE, 32'd1, 32'd0);
    do_req(1'b0, 1'b1, 2'd3, 4'b0001, 32'h180);
    wait_idle("fill");

    // Simultaneous save and restore: save wins.
    push(K_CWP, 32'd1, 32'd0); push(K_DONE, 32'd0, 32'd0);
    do_req(1'b1, 1'b1, 2'd2, 4'b0000, 32'h0);
    wait_idle("save_restore_same_cycle");

    // Spill with address wrap past 2^32, window 1.
    push_spill(32'hFFFF_FFF0, 1, 4'b0001);
    do_req(1'b1, 1'b0, 2'd2, 4'b0010, 32'hFFFF_FFF0);
    wait_idle("spill_addr_wrap");

    // Request while busy is ignored: exactly one operation completes.
    push_spill(32'h2000, 0, 4'b1000);
    do_req(1'b1, 1'b0, 2'd1, 4'b0001, 32'h2000);
    repeat (5) @(negedge Clk);
    do_req(1'b1, 1'b0, 2'd3, 4'b0000, 32'h0);
    do_req(1'b0, 1'b1, 2'd0, 4'b0000, 32'h0);
    wait_idle("req_while_busy");

    // Reset at word 7 of a spill aborts it with no PSR update.
    begin
      int base;
      bit reached;
      base = n_mem_wr;
      reached = 1'b0;
      for (int k = 0; k < 7; k++) push(K_MWR, 32'h300 + 32'(4 * k), rf_pat(0, 16 + k));
      do_req(1'b1, 1'b0, 2'd1, 4'b0001, 32'h300);
      for (int i = 0; i < 500; i++) begin
        if (n_mem_wr >= base + 7) begin
          reached = 1'b1;
          break;
        end
        @(negedge Clk);
      end
      n_checks++;
      if (!reached) begin
        n_errors++;
        $display("FAIL reset_spill_reach_word7: got %0d words, required 7", n_mem_wr - base);
      end
      @(posedge Clk);
      #3 RESET = 1'b1;
      #1 check_outs_zero("reset_mid_spill");
      @(negedge Clk);
      RESET = 1'b0;
      repeat (4) @(negedge Clk);
      check_outs_zero("after_reset_idle");
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL reset_spill_words: got %0d pending, required 0", exp_q.size());
        exp_q.delete();
      end
    end
    push(K_CWP, 32'd1, 32'd0); push(K_DONE, 32'd0, 32'd0);
    do_req(1'b1, 1'b0, 2'd2, 4'b0000, 32'h0);
    wait_idle("save_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_spill_fill_ctrl.md
WINDOW_SPILL_FILL_CTRL -- requirements
Module: window_spill_fill_ctrl

Interface
REQ-001 Parameter NWIN, default 4, number of register windows.
REQ-002 Parameter NREG, default 16, registers spilled or filled per window (logical r16..r31, locals plus ins).
REQ-003 One clock; reset is asynchronous and active-high; ports Clk and RESET.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 RESET  in  1  asynchronous active-high reset.
REQ-006 save_req, restore_req  in  1 each  single-cycle SAVE or RESTORE request from the control unit.
REQ-007 cwp_in  in  2  current window pointer from PSR.
REQ-008 wim_in  in  4  window invalid mask.
REQ-009 sp_in  in  32  memory base for the spill/fill block, word aligned.
REQ-010 cwp_out  out  2, and cwp_we  out  1, new CWP and its one-cycle write strobe to PSR.
REQ-011 wim_out  out  4, and wim_we  out  1, new WIM and its one-cycle write strobe.
REQ-012 rf_win  out  2, and rf_addr  out  5, register file window and logical register.
REQ-013 rf_we  out  1, and rf_wdata  out  32, fill write to the register file.
REQ-014 rf_rdata  in  32  register file read data, combinational from rf_win/rf_addr.
REQ-015 mem_addr  out  32, mem_wdata  out  32, mem_rw  out  1 (1=write), mem_en  out  1.
REQ-016 mem_rdata  in  32, and MFC  in  1, memory data and memory-function-complete.
REQ-017 busy  out  1, done  out  1 (one-cycle pulse), overflow  out  1, underflow  out  1.

Function
REQ-018 IDLE state: a request is accepted only when busy=0; requests arriving while busy SHALL be ignored.
REQ-019 If save_req and restore_req are both asserted in the same cycle, save SHALL win.
REQ-020 SAVE target window = (cwp_in-1) mod NWIN; RESTORE target window = (cwp_in+1) mod NWIN; the target window is latched in the accept cycle, along with sp_in and wim_in.
REQ-021 If wim[target]=0: next cycle UPDATE; cwp_we=1 with cwp_out=target; done=1; total latency 2 cycles.
REQ-022 SAVE with wim[target]=1: overflow=1 for the whole operation; SPILL of window target, words k=0..NREG-1.
REQ-023 Spill word k: rf_win=target, rf_addr=16+k, mem_addr=sp+4k, mem_wdata=rf_rdata, mem_rw=1, mem_en=1; mem_en is held until MFC=1.
REQ-024 RESTORE with wim[target]=1: underflow=1 for the whole operation; FILL of window target.
REQ-025 Fill word k: mem_addr=sp+4k, mem_rw=0, mem_en=1 held until MFC; in the cycle after MFC, rf_we=1 with rf_wdata equal to the captured mem_rdata.
REQ-026 After the last word, UPDATE: wim_we=1 with wim_out=WIM rotated right by 1 for SAVE and rotated left by 1 for RESTORE; cwp_we=1 with cwp_out=target, in the same cycle; done=1 in the next cycle.
REQ-027 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-028 Window arithmetic SHALL wrap modulo NWIN: a SAVE from cwp=0 targets window 3, and a RESTORE from cwp=3 targets window 0.
REQ-029 MFC asserted when mem_en=0 SHALL be ignored.
REQ-030 wim_in=0 SHALL never trap.
REQ-031 State machine states: IDLE, CHECK, SPILL, FILL_WAIT, FILL_WR, UPDATE, DONE.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 RESET SHALL force IDLE and set every output to 0, with no cwp_we or wim_we issued.
REQ-034 RESET during SPILL or FILL SHALL abort the operation; CWP and WIM are left unmodified.

Structure
REQ-035 Shared package sparc_win_pkg SHALL hold the state enum, NWIN, NREG, and the rotate-WIM and window-increment/decrement functions.
REQ-036 Word counter sub-module win_word_counter: 4-bit counter with clear, enable and terminal-count outputs.

Verification
REQ-037 Scenario: cwp=2, wim=0001, save -> cwp_out=1, no trap, done 2 cycles after request.
REQ-038 Scenario: cwp=1, wim=0001, sp=0x180, save, MFC 2 cycles after each mem_en -> overflow; 16 writes to 0x180..0x1BC carrying window 0 r16..r31; then wim_out=1000 and cwp_out=0.
REQ-039 Scenario: cwp=3, wim=0001, sp=0x180, restore -> underflow; 16 reads fill window 0; then wim_out=0010 and cwp_out=0.
REQ-040 Scenario: save and restore in the same cycle with wim=0 and cwp=2 -> save only, cwp_out=1.
REQ-041 Scenario: RESET asserted at word 7 of a spill -> all outputs 0, no cwp_we or wim_we; a new save is accepted after RESET falls.
REQ-042 Scenario: save_req asserted while busy -> ignored; exactly one done pulse.
